// File: rtl/mux_lookup_arb_if.sv
// Bundle for mux_lookup_arb: producer lanes, select/mode control and the
// registered output stage.
//   master : producer/consumer side (drives in_valid, in_data, sel, mode, out_ready)
//   slave  : arbiter side (drives in_ready, out_valid, out_data, out_chan, sel_err)
interface mux_lookup_arb_if #(
  parameter int N     = 8,
  parameter int W     = 8,
  parameter int SEL_W = 3
);
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic [N*W-1:0]   in_data;
  logic [SEL_W-1:0] sel;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [SEL_W-1:0] out_chan;
  logic             sel_err;

  modport master (
    output in_valid, in_data, sel, mode, out_ready,
    input  in_ready, out_valid, out_data, out_chan, sel_err
  );

  modport slave (
    input  in_valid, in_data, sel, mode, out_ready,
    output in_ready, out_valid, out_data, out_chan, sel_err
  );
endinterface

// File: rtl/mux_lookup_arb.sv
// N-channel, W-bit lookup mux with per-channel valid/ready, a one-entry
// registered output stage and two selection modes (fixed select / round-robin).
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-high reset
//   io    : mux_lookup_arb_if.slave (io_in_*, io_sel, io_mode, io_out_*, io_sel_err)
module mux_lookup_arb #(
  parameter int N     = 8,
  parameter int W     = 8,
  parameter int SEL_W = 3
) (
  input logic           clock,
  input logic           reset,
  mux_lookup_arb_if.slave io
);

  localparam logic [SEL_W:0]   N_EXT = (SEL_W + 1)'(N);
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(N - 1);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] cand;
  logic [SEL_W:0]   rr_idx;
  logic             found;
  logic             load_en;
  logic             sel_oob;
  logic             grant;
  logic [W-1:0]     sel_data;

  // Candidate selection and grant; in_data is only used for sel_data, which
  // feeds the output register, so no data-to-output combinational path exists.
  always_comb begin
    load_en = !io.out_valid || io.out_ready;
    sel_oob = {1'b0, io.sel} >= N_EXT;
    found   = 1'b0;
    cand    = '0;
    rr_idx  = '0;
    if (io.mode) begin
      // Scan ptr, ptr+1, ... wrapping modulo N; first valid channel wins.
      for (int unsigned i = 0; i < N; i++) begin
        rr_idx = {1'b0, ptr} + (SEL_W + 1)'(i);
        if (rr_idx >= N_EXT) rr_idx = rr_idx - N_EXT;
        if (!found && io.in_valid[rr_idx[SEL_W-1:0]]) begin
          found = 1'b1;
          cand  = rr_idx[SEL_W-1:0];
        end
      end
    end else if (!sel_oob) begin
      found = io.in_valid[io.sel];
      cand  = io.sel;
    end
    grant       = found && load_en;
    io.in_ready = '0;
    if (grant) io.in_ready[cand] = 1'b1;
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (SEL_W'(k) == cand) sel_data = io.in_data[k*W +: W];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io.out_valid <= 1'b0;
      io.out_data  <= '0;
      io.out_chan  <= '0;
      io.sel_err   <= 1'b0;
      ptr          <= '0;
    end else begin
      io.sel_err <= !io.mode && sel_oob;
      if (grant) begin
        io.out_valid <= 1'b1;
        io.out_data  <= sel_data;
        io.out_chan  <= cand;
        if (io.mode) ptr <= (cand == LAST) ? '0 : cand + 1'b1;
      end else if (io.out_ready) begin
        // Drained with nothing to replace it; data/chan keep stale values.
        io.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mux_lookup_arb.md
Name: mux_lookup_arb

Overview:
- Parametrised N-channel, W-bit successor to the 8:1 single-bit lookup mux.
- Adds per-channel valid/ready handshake, a one-entry registered output stage, and two selection modes: fixed select and round-robin scan.
- Sits between multiple producer lanes and a single downstream consumer. Replaces hand-chained lookup muxes in datapath steering.

Parameters:
- N, 8, number of input channels (2..32, power of two not required)
- W, 8, data width per channel in bits
- SEL_W, 3, select/channel-index width, equals ceil(log2(N))

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- io_in_valid  input  N  bit k: channel k offers data
- io_in_ready  output  N  bit k: channel k's data is taken this cycle
- io_in_data  input  N*W  channel k occupies bits [k*W+W-1 : k*W]
- io_sel  input  SEL_W  channel index used in fixed mode
- io_mode  input  1  0 = fixed select, 1 = round-robin
- io_out_valid  output  1  output register holds data
- io_out_ready  input  1  consumer accepts data
- io_out_data  output  W  registered data
- io_out_chan  output  SEL_W  source channel of io_out_data
- io_sel_err  output  1  registered flag, high for one cycle after a fixed-mode cycle with io_sel >= N

Behaviour:
- Reset (async assert, sync release):
  - io_out_valid = 0; io_out_data = 0; io_out_chan = 0; io_sel_err = 0.
  - Round-robin pointer ptr = 0.
- load_en = !io_out_valid || io_out_ready. The register accepts new data when empty, or when draining in the same cycle (full throughput, no bubble).
- Fixed mode (io_mode=0):
  - Candidate is io_sel when io_sel < N and io_in_valid[io_sel] = 1.
  - io_sel >= N: no grant, all io_in_ready = 0, io_sel_err = 1 on the next cycle.
  - ptr is not modified.
- Round-robin mode (io_mode=1):
  - Candidate is the first k with io_in_valid[k] = 1, scanning ptr, ptr+1, … , N-1, 0, … , ptr-1 (wrap modulo N).
  - io_sel is ignored; io_sel_err is 0.
- Grant:
  - Grant occurs when a candidate exists and load_en = 1.
  - io_in_ready[candidate] = 1; every other io_in_ready bit is 0.
  - io_in_ready is combinational from io_in_valid, io_sel, io_mode, ptr, io_out_valid and io_out_ready. It never depends on io_in_data.
- On grant, at the next edge:
  - io_out_data = selected data; io_out_chan = candidate; io_out_valid = 1.
  - In round-robin mode: ptr = (candidate+1) mod N. Wrap from N-1 goes to 0, including non-power-of-two N.
- No grant with io_out_ready = 1 and io_out_valid = 1: next cycle io_out_valid = 0; io_out_data and io_out_chan hold their stale values.
- Backpressure: while io_out_valid = 1 and io_out_ready = 0, io_out_data and io_out_chan are stable and all io_in_ready = 0.
- Latency: 1 cycle from the input handshake to io_out_valid.
- Mode switch: takes effect in the same cycle (combinational). ptr is retained across fixed-mode periods.
- Simultaneous drain and load: the old word leaves and the new word is captured on the same edge. No data is lost or duplicated.
- Reset mid-transfer: the in-flight output word is discarded; the next grant follows the reset-state rules (ptr = 0).
- No combinational path from io_in_data to any output.

Test Plan:
- Reset then fixed mode, io_sel=5, io_in_valid=0xFF, data[k]=0x10+k, io_out_ready=1 -> io_in_ready=0x20; next cycle io_out_valid=1, io_out_data=0x15, io_out_chan=5.
- Round-robin, all 8 channels valid, io_out_ready=1 for 10 cycles -> io_out_chan sequence 0,1,…,7,0,1; one word every cycle, no bubbles.
- Round-robin, io_in_valid=0x81, ptr=1 -> grants 7, then 0, then 7; sparse-channel wrap verified.
- Backpressure: word from channel 3 loaded, io_out_ready=0 for 4 cycles -> io_out_data stable, io_in_ready=0 throughout; io_out_ready=1 with channel 4 valid -> channel 4's word captured on the same edge that drains channel 3's.
- N=6 build, fixed mode, io_sel=7 -> io_in_ready=0, io_sel_err=1 next cycle, io_out_valid stays 0; round-robin from ptr=5 wraps to 0.
- Assert reset while io_out_valid=1 and ptr=4 -> io_out_valid, io_out_data and io_out_chan drop to 0 immediately (no clock edge needed); first round-robin grant after release starts scan at channel 0.
